// File: rtl/bcd_display_driver.sv
// bcd_display_driver
//
// Two-digit multiplexed 7-segment display driver. It captures the tens and
// units BCD nibbles from the 00-99 counter on a load strobe. It then
// time-multiplexes the two digits onto one shared segment bus, with one
// digit-enable line per digit. All outputs are registered.
//
// Features:
//   - Refresh rate set by REFRESH_DIV.
//   - One dark (dead-time) cycle at the start of every digit slot.
//   - Optional blanking of a leading zero in the tens digit.
//   - A dash (segment g only) for non-BCD codes 10-15.
//
// Parameters:
//   REFRESH_DIV         clk cycles per digit slot (>= 2)
//   ACTIVE_LOW          1: seg/dp/an are active-low, 0: active-high
//   BLANK_LEADING_ZERO  1: tens digit is dark when it is 0
//
// Ports:
//   clk   in   system clock
//   clr   in   asynchronous active-high reset
//   msb   in   [3:0] tens digit (BCD)
//   lsb   in   [3:0] units digit (BCD)
//   load  in   capture strobe for msb/lsb
//   seg   out  [6:0] segments {g,f,e,d,c,b,a}
//   dp    out  decimal point, always inactive
//   an    out  [1:0] digit enables, an[0]=units, an[1]=tens
module bcd_display_driver #(
    parameter int REFRESH_DIV        = 50000,
    parameter bit ACTIVE_LOW         = 1'b1,
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] msb,
    input  logic [3:0] lsb,
    input  logic       load,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int              CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Inactive ("dark") levels for each output polarity.
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic       DP_OFF  = ACTIVE_LOW ? 1'b1  : 1'b0;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_t;

    logic [3:0]       d_msb_q, d_msb_d;
    logic [3:0]       d_lsb_q, d_lsb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            slot_q, slot_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             dp_q, dp_d;

    logic [3:0] digit;
    logic [6:0] seg_on;
    logic [1:0] an_on;
    logic       lit;

    // Next-state logic for the digit registers, prescaler and slot bit.
    // The slot toggles on the same edge that the prescaler wraps.
    always_comb begin
        d_msb_d = d_msb_q;
        d_lsb_d = d_lsb_q;
        cnt_d   = cnt_q + 1'b1;
        slot_d  = slot_q;
        if (load) begin
            d_msb_d = msb;
            d_lsb_d = lsb;
        end
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            slot_d = (slot_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
        end
    end

    // Output decode from the current (pre-edge) state. The whole output set
    // is registered together, so a digit change and a slot change land on
    // the pins on the same edge. Old and new values never mix in a lit cycle.
    always_comb begin
        digit  = (slot_q == SLOT_TENS) ? d_msb_q : d_lsb_q;
        an_on  = (slot_q == SLOT_TENS) ? 2'b10 : 2'b01;
        // cnt=0 is the dead cycle; a zero tens digit may also be blanked.
        lit    = (cnt_q != '0) &&
                 !((slot_q == SLOT_TENS) && BLANK_LEADING_ZERO &&
                   (d_msb_q == 4'd0));
        seg_on = 7'h40;
        case (digit)
            4'd0:    seg_on = 7'h3F;
            4'd1:    seg_on = 7'h06;
            4'd2:    seg_on = 7'h5B;
            4'd3:    seg_on = 7'h4F;
            4'd4:    seg_on = 7'h66;
            4'd5:    seg_on = 7'h6D;
            4'd6:    seg_on = 7'h7D;
            4'd7:    seg_on = 7'h07;
            4'd8:    seg_on = 7'h7F;
            4'd9:    seg_on = 7'h6F;
            default: seg_on = 7'h40;
        endcase
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        dp_d  = DP_OFF;
        if (lit) begin
            seg_d = ACTIVE_LOW ? ~seg_on : seg_on;
            an_d  = ACTIVE_LOW ? ~an_on : an_on;
        end
    end

    // State and output registers. Reset forces the outputs dark right away,
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            d_msb_q <= 4'd0;
            d_lsb_q <= 4'd0;
            cnt_q   <= '0;
            slot_q  <= SLOT_UNITS;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            dp_q    <= DP_OFF;
        end else begin
            d_msb_q <= d_msb_d;
            d_lsb_q <= d_lsb_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver
//
// Testbench for bcd_display_driver with REFRESH_DIV=4. Three instances share
// the same stimulus:
//   dut     active-low, leading-zero blanking on
//   dut_nb  active-low, leading-zero blanking off
//   dut_ah  active-high, leading-zero blanking on
// A behavioural model of the display pushes the expected outputs for each
// edge into a queue as the stimulus is driven. Each scenario pops an entry
// after the edge and compares it with all three instances.
module tb_bcd_display_driver;

    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       load;
    logic [3:0] msb;
    logic [3:0] lsb;
    logic [6:0] seg, seg_nb, seg_ah;
    logic [1:0] an, an_nb, an_ah;
    logic       dp, dp_nb, dp_ah;

    always #5 clk = ~clk;

    bcd_display_driver #(.REFRESH_DIV(RDIV), .ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)) dut (
        .clk(clk), .clr(clr), .msb(msb), .lsb(lsb), .load(load),
        .seg(seg), .dp(dp), .an(an));

    bcd_display_driver #(.REFRESH_DIV(RDIV), .ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)) dut_nb (
        .clk(clk), .clr(clr), .msb(msb), .lsb(lsb), .load(load),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb));

    bcd_display_driver #(.REFRESH_DIV(RDIV), .ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b1)) dut_ah (
        .clk(clk), .clr(clr), .msb(msb), .lsb(lsb), .load(load),
        .seg(seg_ah), .dp(dp_ah), .an(an_ah));

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic       dp;
        logic [6:0] seg_nb;
        logic [1:0] an_nb;
        logic [6:0] seg_ah;
        logic [1:0] an_ah;
        logic       dp_ah;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    // Model state of the display.
    int         m_cnt;
    logic       m_slot;
    logic [3:0] m_msb, m_lsb;
    logic [6:0] dec_tab [16];

    initial begin
        dec_tab[0] = 7'h3F; dec_tab[1] = 7'h06; dec_tab[2] = 7'h5B; dec_tab[3] = 7'h4F;
        dec_tab[4] = 7'h66; dec_tab[5] = 7'h6D; dec_tab[6] = 7'h7D; dec_tab[7] = 7'h07;
        dec_tab[8] = 7'h7F; dec_tab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'h40;
    end

    // Expected outputs after the next edge, taken from the model state
    // before that edge.
    function automatic exp_t predict();
        exp_t       r;
        logic       lit_b, lit_n;
        logic [6:0] seg_h;
        logic [1:0] an_h;
        lit_b    = (m_cnt != 0) && !(m_slot && (m_msb == 4'd0));
        lit_n    = (m_cnt != 0);
        seg_h    = dec_tab[m_slot ? m_msb : m_lsb];
        an_h     = m_slot ? 2'b10 : 2'b01;
        r.seg    = lit_b ? ~seg_h : 7'h7F;
        r.an     = lit_b ? ~an_h  : 2'b11;
        r.dp     = 1'b1;
        r.seg_nb = lit_n ? ~seg_h : 7'h7F;
        r.an_nb  = lit_n ? ~an_h  : 2'b11;
        r.seg_ah = lit_b ? seg_h : 7'h00;
        r.an_ah  = lit_b ? an_h  : 2'b00;
        r.dp_ah  = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_slot = 1'b0;
        m_msb  = 4'd0;
        m_lsb  = 4'd0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, record the expected output, advance the
    // model, then wait past the edge so the DUT outputs have settled.
    task automatic drive_edge(input logic ld, input logic [3:0] m, input logic [3:0] l);
        load = ld;
        msb  = m;
        lsb  = l;
        exp_q.push_back(predict());
        if (ld) begin
            m_msb = m;
            m_lsb = l;
        end
        if (m_cnt == RDIV - 1) begin
            m_cnt  = 0;
            m_slot = ~m_slot;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] an_ref [8];
        an_ref = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        clr  = 1'b1;
        load = 1'b0;
        msb  = 4'd0;
        lsb  = 4'd0;
        #1;
        total++;
        if (seg !== 7'h7F || an !== 2'b11 || dp !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_low: seg=%h an=%b dp=%b expected seg=7f an=11 dp=1", seg, an, dp);
        end
        total++;
        if (seg_ah !== 7'h00 || an_ah !== 2'b00 || dp_ah !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_high: seg=%h an=%b dp=%b expected seg=00 an=00 dp=0", seg_ah, an_ah, dp_ah);
        end
        // A load during reset must not be captured.
        load = 1'b1;
        msb  = 4'd8;
        lsb  = 4'd8;
        @(posedge clk);
        #1;
        load = 1'b0;
        clr  = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive_edge(1'b0, 4'd0, 4'd0);
            e = exp_q.pop_front();
            total++;
            if (an !== an_ref[i]) begin
                bad++;
                $display("[TB] FAIL reset_seq_an[%0d]: an=%b expected %b", i + 1, an, an_ref[i]);
            end
            total++;
            if (seg !== e.seg || an !== e.an || dp !== e.dp) begin
                bad++;
                $display("[TB] FAIL reset_seq[%0d]: seg=%h an=%b dp=%b expected seg=%h an=%b dp=%b",
                         i + 1, seg, an, dp, e.seg, e.an, e.dp);
            end
            total++;
            if (seg_nb !== e.seg_nb || an_nb !== e.an_nb || seg_ah !== e.seg_ah || an_ah !== e.an_ah || dp_ah !== e.dp_ah) begin
                bad++;
                $display("[TB] FAIL reset_seq_var[%0d]: nb=%h/%b ah=%h/%b expected nb=%h/%b ah=%h/%b",
                         i + 1, seg_nb, an_nb, seg_ah, an_ah, e.seg_nb, e.an_nb, e.seg_ah, e.an_ah);
            end
        end
    endtask

    task automatic test_two_digits();
        logic saw_units = 1'b0;
        logic saw_tens  = 1'b0;
        for (int i = 0; i < 4 * RDIV + 1; i++) begin
            drive_edge(i == 0, 4'd4, 4'd2);
            e = exp_q.pop_front();
            if (an == 2'b10 && seg == 7'h24) saw_units = 1'b1;
            if (an == 2'b01 && seg == 7'h19) saw_tens = 1'b1;
            total++;
            if (seg !== e.seg || an !== e.an || seg_nb !== e.seg_nb || an_nb !== e.an_nb || seg_ah !== e.seg_ah || an_ah !== e.an_ah) begin
                bad++;
                $display("[TB] FAIL two_digits[%0d]: seg=%h an=%b nb=%h/%b ah=%h/%b expected seg=%h an=%b nb=%h/%b ah=%h/%b",
                         i, seg, an, seg_nb, an_nb, seg_ah, an_ah, e.seg, e.an, e.seg_nb, e.an_nb, e.seg_ah, e.an_ah);
            end
        end
        total++;
        if (!(saw_units && saw_tens)) begin
            bad++;
            $display("[TB] FAIL two_digits_seen: units=%b tens=%b expected 1 1", saw_units, saw_tens);
        end
    endtask

    task automatic test_leading_zero();
        logic saw_tens_nb = 1'b0;
        for (int i = 0; i < 4 * RDIV + 1; i++) begin
            drive_edge(i == 0, 4'd0, 4'd7);
            e = exp_q.pop_front();
            if (an_nb == 2'b01 && seg_nb == 7'h40) saw_tens_nb = 1'b1;
            total++;
            if (seg !== e.seg || an !== e.an || seg_nb !== e.seg_nb || an_nb !== e.an_nb || seg_ah !== e.seg_ah || an_ah !== e.an_ah) begin
                bad++;
                $display("[TB] FAIL leading_zero[%0d]: seg=%h an=%b nb=%h/%b ah=%h/%b expected seg=%h an=%b nb=%h/%b ah=%h/%b",
                         i, seg, an, seg_nb, an_nb, seg_ah, an_ah, e.seg, e.an, e.seg_nb, e.an_nb, e.seg_ah, e.an_ah);
            end
        end
        total++;
        if (!saw_tens_nb) begin
            bad++;
            $display("[TB] FAIL leading_zero_nb: tens zero seen=%b expected 1", saw_tens_nb);
        end
    endtask

    task automatic test_invalid_code();
        logic saw_dash = 1'b0;
        for (int i = 0; i < 2 * RDIV + 1; i++) begin
            drive_edge(i == 0, 4'd0, 4'd12);
            e = exp_q.pop_front();
            if (an == 2'b10 && seg == 7'h3F) saw_dash = 1'b1;
            total++;
            if (seg !== e.seg || an !== e.an || dp !== e.dp || seg_ah !== e.seg_ah || an_ah !== e.an_ah) begin
                bad++;
                $display("[TB] FAIL invalid_code[%0d]: seg=%h an=%b dp=%b ah=%h/%b expected seg=%h an=%b dp=%b ah=%h/%b",
                         i, seg, an, dp, seg_ah, an_ah, e.seg, e.an, e.dp, e.seg_ah, e.an_ah);
            end
        end
        total++;
        if (!saw_dash) begin
            bad++;
            $display("[TB] FAIL invalid_dash: dash seen=%b expected 1", saw_dash);
        end
    endtask

    task automatic test_async_reset();
        // Restart from a known point, then run until cnt=2 in the units slot.
        clr = 1'b1;
        #1;
        clr = 1'b0;
        model_reset();
        drive_edge(1'b1, 4'd3, 4'd5);
        e = exp_q.pop_front();
        drive_edge(1'b0, 4'd0, 4'd0);
        e = exp_q.pop_front();
        total++;
        if (an !== 2'b10 || seg !== ~7'h6D) begin
            bad++;
            $display("[TB] FAIL async_pre: seg=%h an=%b expected seg=%h an=10", seg, an, ~7'h6D);
        end
        #2;
        clr = 1'b1;
        #1;
        total++;
        if (an !== 2'b11 || seg !== 7'h7F || dp !== 1'b1 || an_ah !== 2'b00 || seg_ah !== 7'h00) begin
            bad++;
            $display("[TB] FAIL async_clr: seg=%h an=%b dp=%b ah=%h/%b expected seg=7f an=11 dp=1 ah=00/00",
                     seg, an, dp, seg_ah, an_ah);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * RDIV; i++) begin
            drive_edge(1'b0, 4'd0, 4'd0);
            e = exp_q.pop_front();
            total++;
            if (seg !== e.seg || an !== e.an || dp !== e.dp || seg_nb !== e.seg_nb || an_nb !== e.an_nb || seg_ah !== e.seg_ah || an_ah !== e.an_ah) begin
                bad++;
                $display("[TB] FAIL async_restart[%0d]: seg=%h an=%b dp=%b nb=%h/%b ah=%h/%b expected seg=%h an=%b dp=%b nb=%h/%b ah=%h/%b",
                         i + 1, seg, an, dp, seg_nb, an_nb, seg_ah, an_ah, e.seg, e.an, e.dp, e.seg_nb, e.an_nb, e.seg_ah, e.an_ah);
            end
        end
    endtask

    task automatic test_tracking();
        logic switched = 1'b0;
        int   tens_one = 0;
        for (int i = 0; i < 4 * RDIV; i++) begin
            // The counter steps 09 -> 10 on the edge where the slot becomes tens.
            if (!switched && m_cnt == RDIV - 1 && m_slot == 1'b0 && i >= RDIV) begin
                switched = 1'b1;
            end
            if (switched) drive_edge(1'b1, 4'd1, 4'd0);
            else          drive_edge(1'b1, 4'd0, 4'd9);
            e = exp_q.pop_front();
            if (an == 2'b01 && seg == 7'h79) tens_one++;
            total++;
            if (seg !== e.seg || an !== e.an || seg_nb !== e.seg_nb || an_nb !== e.an_nb || seg_ah !== e.seg_ah || an_ah !== e.an_ah) begin
                bad++;
                $display("[TB] FAIL tracking[%0d]: seg=%h an=%b nb=%h/%b ah=%h/%b expected seg=%h an=%b nb=%h/%b ah=%h/%b",
                         i, seg, an, seg_nb, an_nb, seg_ah, an_ah, e.seg, e.an, e.seg_nb, e.an_nb, e.seg_ah, e.an_ah);
            end
        end
        total++;
        if (tens_one < RDIV - 1) begin
            bad++;
            $display("[TB] FAIL tracking_tens: lit tens '1' cycles=%0d expected >= %0d", tens_one, RDIV - 1);
        end
    endtask

    initial begin
        test_reset();
        test_two_digits();
        test_leading_zero();
        test_invalid_code();
        test_async_reset();
        test_tracking();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
